multi_timer: RTL
================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels, 1..16, power of two.
REQ-002 Parameter WIDTH, default 32: counter and compare width, 8..32.
REQ-003 Parameter PRESCALE_W, default 8: prescaler reload width, 1..8.
REQ-004 Port input_clk  input  1: system clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset; clock input_clk.
REQ-006 Port sel  input  1: block select from the SoC address decoder.
REQ-007 Port addr  input  log2(NUM_CH)+2: word address; addr[1:0] is the register, upper bits are the channel.
REQ-008 Port we  input  4: byte write mask, bit n enables wdata[8n+7:8n].
REQ-009 Port wdata  input  32: write data.
REQ-010 Port rdata  output  32: combinational read data for the addressed register.
REQ-011 Port irq  output  1: level interrupt request.

Function
REQ-012 Each channel SHALL hold the following registers: COMPARE (reg 0, WIDTH bits), COUNT (reg 1, WIDTH bits), CTRL (reg 2), STATUS (reg 3).
- CTRL bit0 is EN, bit1 is AUTO (auto-reload), bit2 is IE, and bits[15:8] are PRE (PRESCALE_W bits, zero-extended).
REQ-013 A write SHALL occur when sel=1 and we!=0.
- Writes are accepted only to the channel and register selected by addr.
- Only the bytes enabled by we are updated.
REQ-014 Reads SHALL be combinational with zero latency.
- Unused bits read 0.
- rdata is 0 when sel=0.
REQ-015 Each channel SHALL have a prescaler counter that counts 0..PRE while EN=1.
- A tick occurs in the cycle where the prescaler equals PRE; the prescaler then returns to 0.
- With PRE=0, a tick occurs every cycle.
REQ-016 On a tick, if COUNT==COMPARE:
- PENDING is set to 1.
- If AUTO=1, COUNT goes to 0 and counting continues.
- If AUTO=0, EN is cleared and COUNT holds its value (one-shot).
REQ-017 On a tick with COUNT!=COMPARE, COUNT SHALL increment modulo 2^WIDTH.
- Consequently, lowering COMPARE below COUNT causes the next match to occur only after the counter wraps.
REQ-018 While EN=0, COUNT and the prescaler SHALL hold their values.
REQ-019 A write of any value to COUNT SHALL clear both COUNT and the prescaler to 0.
- This clear takes priority over a tick in the same cycle.
REQ-020 STATUS read SHALL return bit0 = that channel's PENDING and bits[16+NUM_CH-1:16] = the PENDING vector of all channels.
REQ-021 Writing STATUS with wdata[0]=1 and we[0]=1 SHALL clear PENDING (write-1-to-clear).
- If a match occurs in the same cycle, set wins and PENDING stays 1.
REQ-022 A write to CTRL that sets EN from 0 to 1 SHALL NOT alter COUNT or the prescaler.
REQ-023 irq SHALL be the registered OR over channels of (PENDING & IE).
- It asserts one cycle after PENDING or IE becomes 1.
REQ-024 If a channel's one-shot match and a CTRL write setting EN=1 occur in the same cycle, the CTRL write SHALL win.

Reset
REQ-025 On reset, per channel: COMPARE = all ones; COUNT, prescaler, CTRL and PENDING = 0.
REQ-026 On reset, irq = 0 and no tick or match occurs until reset deasserts.
REQ-027 Reset asserted mid-count SHALL abort all channels immediately and asynchronously; no PENDING survives.

Verification
REQ-028 Ch0, COMPARE=3, CTRL=EN|AUTO|IE, PRE=0 -> PENDING sets on the 4th enabled cycle; irq rises 1 cycle later; COUNT then reads 0,1,2,3,0.
REQ-029 Ch1, COMPARE=2, PRE=3, one-shot -> match after 12 cycles; EN reads 0; COUNT holds 2; no further PENDING after it is cleared.
REQ-030 Ch2 running with COUNT=10, COMPARE written to 5, WIDTH=8 -> next PENDING occurs only after COUNT wraps 255->0 and reaches 5.
REQ-031 STATUS W1C on ch0 issued in the same cycle as an ch0 auto-reload match -> PENDING=1 and irq stays high.
REQ-032 Ch0 and ch3 both pending, IE set only on ch3 -> STATUS bits[19:16]=4'b1001; irq=1; clearing ch3 drops irq to 0 one cycle later.
REQ-033 Reset pulsed while ch0 is at COUNT=7 with PENDING=1 -> COUNT=0, COMPARE=all ones, irq=0 asynchronously.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent prescaled compare timers
// with a word-addressed register file and a shared level irq.
module multi_timer #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                      input_clk,
  input  logic                      reset,
  input  logic                      sel,
  input  logic [$clog2(NUM_CH)+1:0] addr,
  input  logic [3:0]                we,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      irq
);

  localparam int AW = $clog2(NUM_CH) + 2;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [WIDTH-1:0]      compare_q [NUM_CH];
  logic [WIDTH-1:0]      count_q   [NUM_CH];
  logic [PRESCALE_W-1:0] pre_cnt_q [NUM_CH];
  logic [PRESCALE_W-1:0] pre_q     [NUM_CH];
  logic [NUM_CH-1:0]     en_q;
  logic [NUM_CH-1:0]     auto_q;
  logic [NUM_CH-1:0]     ie_q;
  logic [NUM_CH-1:0]     pending_q;

  logic [CW-1:0]     ch;
  logic              wr;
  logic [NUM_CH-1:0] hit_cmp;
  logic [NUM_CH-1:0] hit_cnt;
  logic [NUM_CH-1:0] hit_ctl;
  logic [NUM_CH-1:0] hit_clr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] match;
  logic [WIDTH-1:0]  cmp_wr;
  logic [31:0]       ctl_wr;

  generate
    if (NUM_CH > 1) begin : g_ch
      assign ch = addr[AW-1:2];
    end else begin : g_ch1
      assign ch = 1'b0;
    end
  endgenerate

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  m
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = m[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ctrl_word(
    input logic                  e,
    input logic                  a,
    input logic                  i,
    input logic [PRESCALE_W-1:0] p
  );
    logic [31:0] v;
    v = '0;
    v[8 +: PRESCALE_W] = p;
    v[2:0] = {i, a, e};
    return v;
  endfunction

  // decode the single write target and per-channel tick/match
  always_comb begin
    wr = sel && (we != 4'd0);
    cmp_wr = WIDTH'(merge(32'(compare_q[ch]), wdata, we));
    ctl_wr = merge(ctrl_word(en_q[ch], auto_q[ch],
                             ie_q[ch], pre_q[ch]), wdata, we);
    for (int i = 0; i < NUM_CH; i++) begin
      hit_cmp[i] = wr && (ch == CW'(i)) && (addr[1:0] == 2'd0);
      hit_cnt[i] = wr && (ch == CW'(i)) && (addr[1:0] == 2'd1);
      hit_ctl[i] = wr && (ch == CW'(i)) && (addr[1:0] == 2'd2);
      hit_clr[i] = wr && (ch == CW'(i)) && (addr[1:0] == 2'd3)
                   && we[0] && wdata[0];
      tick[i]  = en_q[i] && (pre_cnt_q[i] == pre_q[i])
                 && !hit_cnt[i];
      match[i] = tick[i] && (count_q[i] == compare_q[i]);
    end
  end

  // channel state; later assignments give writes their priority
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        compare_q[i] <= '1;
        count_q[i]   <= '0;
        pre_cnt_q[i] <= '0;
        pre_q[i]     <= '0;
      end
      en_q      <= '0;
      auto_q    <= '0;
      ie_q      <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (en_q[i])
          pre_cnt_q[i] <= (pre_cnt_q[i] == pre_q[i]) ? '0
                          : pre_cnt_q[i] + PRESCALE_W'(1);
        if (hit_clr[i])
          pending_q[i] <= 1'b0;
        if (tick[i]) begin
          if (match[i]) begin
            pending_q[i] <= 1'b1;
            if (auto_q[i]) count_q[i] <= '0;
            else           en_q[i]    <= 1'b0;
          end else begin
            count_q[i] <= count_q[i] + WIDTH'(1);
          end
        end
        if (hit_cnt[i]) begin
          count_q[i]   <= '0;
          pre_cnt_q[i] <= '0;
        end
        if (hit_cmp[i])
          compare_q[i] <= cmp_wr;
        if (hit_ctl[i]) begin
          en_q[i]   <= ctl_wr[0];
          auto_q[i] <= ctl_wr[1];
          ie_q[i]   <= ctl_wr[2];
          pre_q[i]  <= ctl_wr[8 +: PRESCALE_W];
        end
      end
    end
  end

  // registered interrupt request
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(pending_q & ie_q);
  end

  // zero-latency register read mux
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[1:0])
        2'd0: rdata = 32'(compare_q[ch]);
        2'd1: rdata = 32'(count_q[ch]);
        2'd2: rdata = ctrl_word(en_q[ch], auto_q[ch],
                                ie_q[ch], pre_q[ch]);
        default: begin
          rdata[0] = pending_q[ch];
          rdata[16 +: NUM_CH] = pending_q;
        end
      endcase
    end
  end

endmodule
